// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: architectural register file with a per-register busy
// scoreboard for long-latency producers in the 5-stage pipeline.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   rd_addr/rd_data NRD packed combinational read ports with write-back bypass
//   rd_busy         per-port "operand not yet available"
//   stall           combinational hazard report (busy operand or blocked issue)
//   issue_valid/rd  mark a destination as pending; issue_ready = accepted
//   wb_valid/rd/data write-back of a result, clears the busy bit
//   busy_vec        registered scoreboard bits
//   pending_cnt     registered popcount of busy_vec
//   stall_cycles    stall statistics counter
//
// Build option: define SCOREBOARD_STATS_EN to build the saturating stall
// counter; otherwise stall_cycles is tied to zero.
module scoreboard_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NRD   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic                stall,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   output logic [NREGS-1:0]    busy_vec,
   output logic [AW:0]         pending_cnt,
   output logic [31:0]         stall_cycles
);

   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] NREGS_W = CW'(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      pending_q;
   logic [AW:0]      pending_d;
   logic             wb_en;
   logic             issue_busy;
   logic             issue_acc;

   // Index lies inside the implemented register range.
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NREGS_W;
   endfunction

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   // Issue acceptance: a pending destination blocks unless retired this cycle.
   always_comb begin
      wb_en       = wb_valid && (wb_rd != '0) && in_range(wb_rd);
      issue_busy  = in_range(issue_rd) ? busy_q[issue_rd] : 1'b0;
      issue_ready = (issue_rd == '0) || !issue_busy || (wb_valid && (wb_rd == issue_rd));
      issue_acc   = issue_valid && issue_ready && (issue_rd != '0) && in_range(issue_rd);
   end

   // Next scoreboard: write-back clears first, so a same-register issue wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (issue_acc) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
      pending_d = popcount(busy_d);
   end

   // Read ports with same-cycle write-back bypass; x0 and out-of-range read 0.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < int'(NRD); i++) begin
         if ((rd_addr[i*AW +: AW] != '0) && in_range(rd_addr[i*AW +: AW])) begin
            if (wb_valid && (wb_rd == rd_addr[i*AW +: AW])) begin
               rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
               rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
               rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
            end
         end
      end
      stall = (|rd_busy) || (issue_valid && !issue_ready);
   end

   // Register array, scoreboard and pending count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
         busy_q    <= '0;
         pending_q <= '0;
      end else begin
         if (wb_en) begin
            regs_q[wb_rd] <= wb_data;
         end
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   assign busy_vec    = busy_q;
   assign pending_cnt = pending_q;

`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of edges that see stall asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Testbench for scoreboard_regfile: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_scoreboard_regfile;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NRD   = 2;

   logic                clk;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                stall;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_ready;
   logic                wb_valid;
   logic [AW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic [NREGS-1:0]    busy_vec;
   logic [AW:0]         pending_cnt;
   logic [31:0]         stall_cycles;

   scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy_vec(busy_vec), .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: plain arrays of register values and pending flags.
   logic [31:0] mregs [NREGS];
   bit          mbusy [NREGS];
   logic [31:0] mstall;

   typedef struct {
      logic        wbv;
      logic [4:0]  wbr;
      logic [31:0] wbd;
      logic        isv;
      logic [4:0]  isr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  busy;
      logic        rdy;
      logic        stl;
      logic [5:0]  pend;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(NREGS); i++) begin
         mregs[i] = '0;
         mbusy[i] = 1'b0;
      end
      mstall = '0;
   endfunction

   function automatic logic m_ready();
      return (issue_rd == 0) || !mbusy[issue_rd] || (wb_valid && (wb_rd == issue_rd));
   endfunction

   function automatic logic [31:0] m_data(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (wb_valid && (wb_rd == a)) return wb_data;
      return mregs[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (wb_valid && (wb_rd == a)) return 1'b0;
      return mbusy[a];
   endfunction

   function automatic logic m_stall();
      return m_busy(rd_addr[4:0]) || m_busy(rd_addr[9:5]) || (issue_valid && !m_ready());
   endfunction

   // Apply the effect of one rising edge to the model using current inputs.
   function automatic void model_edge();
      logic rdy;
      logic stl;
      rdy = m_ready();
      stl = m_stall();
      if (stl && (mstall != 32'hFFFF_FFFF)) mstall = mstall + 1;
      if (wb_valid && (wb_rd != 0)) begin
         mregs[wb_rd] = wb_data;
         mbusy[wb_rd] = 1'b0;
      end
      if (issue_valid && rdy && (issue_rd != 0)) mbusy[issue_rd] = 1'b1;
   endfunction

   task automatic check_model(input string tag);
      logic [31:0] bv;
      int          cnt;
      logic [31:0] sc_exp;
      bv  = '0;
      cnt = 0;
      for (int i = 0; i < int'(NREGS); i++) begin
         bv[i] = mbusy[i];
         cnt  += int'(mbusy[i]);
      end
`ifdef SCOREBOARD_STATS_EN
      sc_exp = mstall;
`else
      sc_exp = 32'h0;
`endif
      chk({tag, ".rd_data0"}, rd_data[31:0], m_data(rd_addr[4:0]));
      chk({tag, ".rd_data1"}, rd_data[63:32], m_data(rd_addr[9:5]));
      chk({tag, ".rd_busy"}, 32'(rd_busy), 32'({m_busy(rd_addr[9:5]), m_busy(rd_addr[4:0])}));
      chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(m_ready()));
      chk({tag, ".stall"}, 32'(stall), 32'(m_stall()));
      chk({tag, ".busy_vec"}, busy_vec, bv);
      chk({tag, ".pending_cnt"}, 32'(pending_cnt), 32'(cnt));
      chk({tag, ".stall_cycles"}, stall_cycles, sc_exp);
   endtask

   task automatic set_idle();
      wb_valid    = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
   endtask

   // Called at posedge+1; ends at the following posedge+1.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [31:0] sc0;

      //            wbv  wbr    wbd            isv  isr   ra0   ra1   d0             d1             busy   rdy  stl  pend
      tbl[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[1]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[2]  = '{1'b1, 5'd0, 32'h1234,      1'b0, 5'd0, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd7, 5'd0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd0, 32'h0,         32'h0,         2'b01, 1'b1, 1'b1, 6'd1};
      tbl[6]  = '{1'b1, 5'd7, 32'h55,        1'b0, 5'd0, 5'd7, 5'd0, 32'h55,        32'h0,         2'b00, 1'b1, 1'b0, 6'd1};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd5, 32'h55,        32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0, 6'd0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 6'd0};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 6'd1};
      tbl[10] = '{1'b1, 5'd9, 32'hA5,        1'b1, 5'd9, 5'd9, 5'd0, 32'hA5,        32'h0,         2'b00, 1'b1, 1'b0, 6'd1};
      tbl[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd9, 32'hA5,        32'hA5,        2'b11, 1'b1, 1'b1, 6'd1};

      // Reset state.
      rst_n   = 1'b0;
      rd_addr = {5'd3, 5'd0};
      set_idle();
      model_reset();
      #1;
      chk("reset.rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
      chk("reset.rd_busy", 32'(rd_busy), 32'h0);
      chk("reset.busy_vec", busy_vec, 32'h0);
      chk("reset.pending_cnt", 32'(pending_cnt), 32'h0);
      chk("reset.issue_ready", 32'(issue_ready), 32'h1);
      chk("reset.stall_cycles", stall_cycles, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed vectors: expectations checked just before the edge.
      for (int i = 0; i < 12; i++) begin
         wb_valid    = tbl[i].wbv;
         wb_rd       = tbl[i].wbr;
         wb_data     = tbl[i].wbd;
         issue_valid = tbl[i].isv;
         issue_rd    = tbl[i].isr;
         rd_addr     = {tbl[i].ra1, tbl[i].ra0};
         #2;
         chk($sformatf("vec%0d.rd_data0", i), rd_data[31:0], tbl[i].d0);
         chk($sformatf("vec%0d.rd_data1", i), rd_data[63:32], tbl[i].d1);
         chk($sformatf("vec%0d.rd_busy", i), 32'(rd_busy), 32'(tbl[i].busy));
         chk($sformatf("vec%0d.issue_ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].stl));
         chk($sformatf("vec%0d.pending_cnt", i), 32'(pending_cnt), 32'(tbl[i].pend));
         check_model($sformatf("vec%0d.model", i));
         tick();
      end
      set_idle();
      rd_addr = {5'd0, 5'd9};
      #2;
      chk("waw.busy_vec9", 32'(busy_vec[9]), 32'h1);
      chk("waw.data9", rd_data[31:0], 32'hA5);

      // Hold a stall for 10 edges on busy x9.
      sc0 = stall_cycles;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold%0d.stall", i), 32'(stall), 32'h1);
         tick();
         #2;
      end
`ifdef SCOREBOARD_STATS_EN
      chk("hold.stall_cycles_delta", stall_cycles - sc0, 32'd10);
`else
      chk("hold.stall_cycles_zero", stall_cycles, 32'h0);
`endif
      #(-0);

      // Asynchronous reset with x4 and x6 pending.
      @(posedge clk);
      model_edge();
      #1;
      issue_valid = 1'b1;
      issue_rd    = 5'd4;
      tick();
      issue_rd    = 5'd6;
      tick();
      set_idle();
      rd_addr = {5'd9, 5'd5};
      #2;
      chk("pre_rst.pending_cnt", 32'(pending_cnt), 32'd3);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst.busy_vec", busy_vec, 32'h0);
      chk("async_rst.pending_cnt", 32'(pending_cnt), 32'h0);
      chk("async_rst.rd_data0", rd_data[31:0], 32'h0);
      chk("async_rst.rd_data1", rd_data[63:32], 32'h0);
      chk("async_rst.stall_cycles", stall_cycles, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_model("post_rst");

      // Randomized traffic, biased toward a few registers to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         wb_valid    = 1'($urandom_range(0, 1));
         wb_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         #2;
         check_model($sformatf("rnd%0d", i));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
